ysyx_24070014_ifu: RTL and testbench

Multicycle instruction fetch unit for the NPC core; sits directly upstream of the decode stage that hosts the immediate generator and supplies it the raw 32-bit `inst`. Holds the PC, issues one read request per instruction on a valid/ready memory interface, captures the response, and presents `inst` and `inst_pc` downstream on a valid/ready handshake. After delivery it waits for the next PC from writeback before fetching again; there is never more than one instruction in flight.

---
 rtl/ysyx_24070014_ifu.sv | 117 +++++++++++
 tb/tb_ysyx_24070014_ifu.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ysyx_24070014_ifu.sv
// Multicycle instruction fetch unit: PC register, one read per instruction, hands inst/inst_pc to decode.
// Latency: request accepted in cycle N, response in N+1 at the earliest, inst_valid in N+2; next request no earlier than N+4.
// Backpressure: every handshake output is decoded from the state register; wait states on ar_ready, r_valid, inst_ready and npc_valid are held off indefinitely.
// Optional feature: define YSYX_24070014_IFU_ALIGN_CHECK_EN to trap misaligned PCs without issuing a memory request.
module ysyx_24070014_ifu #(
  parameter int                   ADDR_LEN = 32,
  parameter int                   INST_LEN = 32,
  parameter logic [ADDR_LEN-1:0]  RESET_PC = ADDR_LEN'(32'h8000_0000)
) (
  input  logic                clk,
  input  logic                rst,
  output logic                mem_ar_valid,
  input  logic                mem_ar_ready,
  output logic [ADDR_LEN-1:0] mem_ar_addr,
  input  logic                mem_r_valid,
  output logic                mem_r_ready,
  input  logic [INST_LEN-1:0] mem_r_data,
  input  logic [1:0]          mem_r_resp,
  output logic                inst_valid,
  input  logic                inst_ready,
  output logic [INST_LEN-1:0] inst,
  output logic [ADDR_LEN-1:0] inst_pc,
  output logic [1:0]          inst_fault,
  input  logic                npc_valid,
  input  logic [ADDR_LEN-1:0] npc
);

  typedef enum logic [1:0] {
    S_REQ      = 2'd0,
    S_RESP     = 2'd1,
    S_DELIVER  = 2'd2,
    S_WAIT_NPC = 2'd3
  } state_t;

  state_t              state;
  logic [ADDR_LEN-1:0] pc;
  logic                fault_acc;
  logic                pc_aligned;

`ifdef YSYX_24070014_IFU_ALIGN_CHECK_EN
  logic                fault_mis;

  // A misaligned PC never reaches memory; it is reported through the normal deliver path.
  assign pc_aligned = (pc[1:0] == 2'b00);
  assign inst_fault = {fault_mis, fault_acc};
`else
  // Without the check every PC is issued as-is and the misaligned flag cannot be raised.
  assign pc_aligned = 1'b1;
  assign inst_fault = {1'b0, fault_acc};
`endif

  // Handshake outputs are pure decodes of registered state, so no input reaches an output combinationally.
  assign mem_ar_valid = (state == S_REQ) && pc_aligned;
  assign mem_ar_addr  = pc;
  assign mem_r_ready  = (state == S_RESP);
  assign inst_valid   = (state == S_DELIVER);

  // Fetch sequencer: request, wait for response, hold result for decode, then wait for writeback's next PC.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_REQ;
      pc        <= RESET_PC;
      inst      <= '0;
      inst_pc   <= '0;
      fault_acc <= 1'b0;
`ifdef YSYX_24070014_IFU_ALIGN_CHECK_EN
      fault_mis <= 1'b0;
`endif
    end else begin
      case (state)
        S_REQ: begin
`ifdef YSYX_24070014_IFU_ALIGN_CHECK_EN
          if (!pc_aligned) begin
            inst      <= '0;
            inst_pc   <= pc;
            fault_acc <= 1'b0;
            fault_mis <= 1'b1;
            state     <= S_DELIVER;
          end else if (mem_ar_ready) begin
            state <= S_RESP;
          end
`else
          if (mem_ar_ready) begin
            state <= S_RESP;
          end
`endif
        end
        S_RESP: begin
          if (mem_r_valid) begin
            // Faulted words are still captured; decode decides whether to trap.
            inst      <= mem_r_data;
            inst_pc   <= pc;
            fault_acc <= |mem_r_resp;
`ifdef YSYX_24070014_IFU_ALIGN_CHECK_EN
            fault_mis <= 1'b0;
`endif
            state     <= S_DELIVER;
          end
        end
        S_DELIVER: begin
          if (inst_ready) begin
            state <= S_WAIT_NPC;
          end
        end
        S_WAIT_NPC: begin
          // Only here is npc honoured; earlier pulses from writeback are stale.
          if (npc_valid) begin
            pc    <= npc;
            state <= S_REQ;
          end
        end
        default: state <= S_REQ;
      endcase
    end
  end

endmodule

// File: tb/tb_ysyx_24070014_ifu.sv
// Directed bench for the fetch unit: a stimulus process plays memory, decode and writeback,
// queueing the expected request addresses and delivered instructions; a monitor on the falling
// edge pops and compares on every handshake and checks hold-stability under backpressure.
module tb_ysyx_24070014_ifu;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_ar_valid;
  logic        mem_ar_ready;
  logic [31:0] mem_ar_addr;
  logic        mem_r_valid;
  logic        mem_r_ready;
  logic [31:0] mem_r_data;
  logic [1:0]  mem_r_resp;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic [1:0]  inst_fault;
  logic        npc_valid;
  logic [31:0] npc;

  ysyx_24070014_ifu dut (
    .clk          (clk),
    .rst          (rst),
    .mem_ar_valid (mem_ar_valid),
    .mem_ar_ready (mem_ar_ready),
    .mem_ar_addr  (mem_ar_addr),
    .mem_r_valid  (mem_r_valid),
    .mem_r_ready  (mem_r_ready),
    .mem_r_data   (mem_r_data),
    .mem_r_resp   (mem_r_resp),
    .inst_valid   (inst_valid),
    .inst_ready   (inst_ready),
    .inst         (inst),
    .inst_pc      (inst_pc),
    .inst_fault   (inst_fault),
    .npc_valid    (npc_valid),
    .npc          (npc)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] pc;
    logic [1:0]  fault;
  } exp_t;

  exp_t        iq[$];
  logic [31:0] aq[$];
  int          vectors     = 0;
  int          miscompares = 0;
  logic        junk_npc    = 1'b0;

  task automatic chk(input string name, input logic [65:0] act, input logic [65:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tmo(input string name);
    vectors++;
    miscompares++;
    $display("FAIL %s: got timeout expected handshake", name);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor: compares handshakes against the queues and checks hold rules under backpressure.
  logic        hold_ar = 1'b0;
  logic        hold_i  = 1'b0;
  logic [31:0] held_addr;
  exp_t        held_i;
  exp_t        got;
  always @(negedge clk) begin
    if (rst) begin
      hold_ar = 1'b0;
      hold_i  = 1'b0;
    end else begin
      got = '{inst: inst, pc: inst_pc, fault: inst_fault};
      if (hold_ar) chk("ar_hold", {33'd0, mem_ar_valid, mem_ar_addr}, {33'd0, 1'b1, held_addr});
      if (hold_i)  chk("inst_hold", {inst_valid, got}, {1'b1, held_i});
      if (mem_ar_valid && mem_ar_ready) begin
        if (aq.size() == 0) chk("ar_unexpected", {34'd0, mem_ar_addr}, 66'd0);
        else chk("ar_addr", {34'd0, mem_ar_addr}, {34'd0, aq.pop_front()});
      end
      if (inst_valid && inst_ready) begin
        if (iq.size() == 0) chk("inst_unexpected", {got}, 66'd0);
        else chk("inst_deliver", {got}, {iq.pop_front()});
      end
      hold_ar   = mem_ar_valid && !mem_ar_ready;
      held_addr = mem_ar_addr;
      hold_i    = inst_valid && !inst_ready;
      held_i    = got;
    end
  end

  task automatic ar_phase(input int wait_cyc);
    bit done = 0;
    mem_ar_ready = 1'b0;
    repeat (wait_cyc) tick();
    mem_ar_ready = 1'b1;
    for (int i = 0; i < 50; i++) begin
      if (mem_ar_valid) begin tick(); done = 1; break; end
      tick();
    end
    mem_ar_ready = 1'b0;
    if (!done) tmo("ar_handshake");
  endtask

  task automatic r_phase(input int wait_cyc, input logic [31:0] data, input logic [1:0] resp);
    bit done = 0;
    mem_r_valid = 1'b0;
    npc_valid   = junk_npc;
    npc         = 32'h8000_0010;
    repeat (wait_cyc) tick();
    mem_r_valid = 1'b1;
    mem_r_data  = data;
    mem_r_resp  = resp;
    for (int i = 0; i < 50; i++) begin
      if (mem_r_ready) begin tick(); done = 1; break; end
      tick();
    end
    mem_r_valid = 1'b0;
    mem_r_data  = 32'hBAD0_BAD0;
    mem_r_resp  = 2'b00;
    if (!done) tmo("r_handshake");
  endtask

  task automatic deliver_phase(input int wait_cyc);
    bit done = 0;
    inst_ready = 1'b0;
    npc_valid  = junk_npc;
    npc        = 32'h8000_0010;
    repeat (wait_cyc) tick();
    inst_ready = 1'b1;
    for (int i = 0; i < 50; i++) begin
      if (inst_valid) begin tick(); done = 1; break; end
      tick();
    end
    inst_ready = 1'b0;
    npc_valid  = 1'b0;
    if (!done) tmo("inst_handshake");
  endtask

  task automatic npc_phase(input logic [31:0] next);
    chk("wait_no_req", {65'd0, mem_ar_valid}, 66'd0);
    npc_valid = 1'b1;
    npc       = next;
    tick();
    npc_valid = 1'b0;
  endtask

  task automatic fetch(input logic [31:0] addr, input logic [31:0] data, input logic [1:0] resp,
                       input logic [1:0] fault, input int arw, input int rw, input int iw,
                       input logic [31:0] next);
    aq.push_back(addr);
    iq.push_back('{inst: data, pc: addr, fault: fault});
    ar_phase(arw);
    r_phase(rw, data, resp);
    deliver_phase(iw);
    npc_phase(next);
  endtask

  initial begin
    rst          = 1'b1;
    mem_ar_ready = 1'b0;
    mem_r_valid  = 1'b0;
    mem_r_data   = '0;
    mem_r_resp   = 2'b00;
    inst_ready   = 1'b0;
    npc_valid    = 1'b0;
    npc          = '0;
    repeat (3) tick();

    // Reset contents.
    chk("rst_r_ready",    {65'd0, mem_r_ready}, 66'd0);
    chk("rst_inst_valid", {65'd0, inst_valid}, 66'd0);
    chk("rst_inst",       {34'd0, inst}, 66'd0);
    chk("rst_inst_pc",    {34'd0, inst_pc}, 66'd0);
    chk("rst_fault",      {64'd0, inst_fault}, 66'd0);
    chk("rst_ar_addr",    {34'd0, mem_ar_addr}, {34'd0, 32'h8000_0000});
    rst = 1'b0;

    // Minimum-latency fetch straight out of reset.
    chk("first_ar_valid", {65'd0, mem_ar_valid}, 66'd1);
    aq.push_back(32'h8000_0000);
    iq.push_back('{inst: 32'h0000_0513, pc: 32'h8000_0000, fault: 2'b00});
    ar_phase(0);
    r_phase(0, 32'h0000_0513, 2'b00);
    chk("lat_inst_valid", {65'd0, inst_valid}, 66'd1);
    deliver_phase(0);
    npc_phase(32'h8000_0004);
    chk("lat_next_req", {65'd0, mem_ar_valid}, 66'd1);

    // Wait states on every handshake.
    fetch(32'h8000_0004, 32'h0010_0093, 2'b00, 2'b00, 3, 4, 2, 32'h8000_0008);

    // Stale npc pulses during RESP and DELIVER must not move the PC.
    junk_npc = 1'b1;
    fetch(32'h8000_0008, 32'h0020_0113, 2'b00, 2'b00, 0, 2, 2, 32'h8000_0020);
    junk_npc = 1'b0;

    // Error response: fault flagged, data still delivered.
    fetch(32'h8000_0020, 32'hDEAD_BEEF, 2'b10, 2'b01, 1, 0, 0, 32'h8000_0002);

    // Misaligned PC.
`ifdef YSYX_24070014_IFU_ALIGN_CHECK_EN
    chk("misal_no_req", {65'd0, mem_ar_valid}, 66'd0);
    iq.push_back('{inst: 32'h0, pc: 32'h8000_0002, fault: 2'b10});
    deliver_phase(1);
    npc_phase(32'h8000_0100);
`else
    fetch(32'h8000_0002, 32'h0000_0013, 2'b00, 2'b00, 0, 0, 0, 32'h8000_0100);
`endif

    // Reset during RESP, then a late response that must be ignored.
    aq.push_back(32'h8000_0100);
    ar_phase(0);
    chk("resp_r_ready", {65'd0, mem_r_ready}, 66'd1);
    rst = 1'b1;
    repeat (2) tick();
    rst         = 1'b0;
    mem_r_valid = 1'b1;
    mem_r_data  = 32'h1111_1111;
    chk("post_rst_r_ready", {65'd0, mem_r_ready}, 66'd0);
    chk("post_rst_ar_addr", {34'd0, mem_ar_addr}, {34'd0, 32'h8000_0000});
    tick();
    mem_r_valid = 1'b0;
    chk("stale_ignored", {65'd0, inst_valid}, 66'd0);
    fetch(32'h8000_0000, 32'h0000_0073, 2'b00, 2'b00, 0, 0, 0, 32'h8000_0004);

    repeat (3) tick();
    chk("aq_empty", {34'd0, 32'(aq.size())}, 66'd0);
    chk("iq_empty", {34'd0, 32'(iq.size())}, 66'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
